pdm_dac: RTL and testbench
==========================

# pdm_dac

Audio output stage sitting directly downstream of the voice controller/mixer. It latches the 16-bit mixed sample on each `audio_valid` pulse, applies a click-free mute/unmute gain ramp, and drives a single-bit pulse-density-modulated (delta-sigma) stream. That stream, after an external RC low-pass filter, is the chip's analog audio. One modulator update occurs every clock cycle.

## Interface
- `RAMP_STEP_LOG2`, default 8: gain changes by 1 LSB every 2^RAMP_STEP_LOG2 clocks. Full ramp = 256·2^RAMP_STEP_LOG2 clocks.
- `clk_i` in 1: system clock, single clock domain.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `audio_valid_i` in 1: one-cycle strobe, `audio_i` valid.
- `audio_i` in 16: mixed sample, signed two's complement.
- `enable_i` in 1: level. 1 = play (ramp up), 0 = mute (ramp down).
- `pdm_o` out 1: registered PDM bitstream.
- `active_o` out 1: registered; 1 when state ≠ MUTED.

## Operation
- Sample register `smp_q` (16 b signed) loads `audio_i` on `audio_valid_i` and holds between strobes. This is a zero-order hold, with no handshake back-pressure.
- Gain `gain_q` is 9 b unsigned, 0..256; 256 = unity.
- `scaled_q` = (smp_q · gain_q) >>> 8, arithmetic shift, 16 b signed.
  - Registered.
  - Never overflows, because gain ≤ 256.
- State machine:
  - MUTED: gain 0. Enter RAMP_UP when `enable_i`=1.
  - RAMP_UP: gain +1 per step tick. When gain reaches 256, go to RUN. If `enable_i`=0, go to RAMP_DOWN from the current gain.
  - RUN: gain 256. If `enable_i`=0, go to RAMP_DOWN.
  - RAMP_DOWN: gain −1 per step tick. When gain reaches 0, go to MUTED. If `enable_i`=1, go to RAMP_UP from the current gain.
- Step prescaler:
  - Counter of RAMP_STEP_LOG2 bits, cleared on every state change.
  - Tick fires when the counter is all-ones.
- Modulator (first-order, default):
  - `x_u` = scaled_q with MSB inverted (offset binary).
  - `{carry, acc_q}` = acc_q + x_u (16 b accumulator).
  - `pdm_o` <= carry.
- Modulator (second-order, see Configuration):
  - fb = `pdm_o` ? +32767 : −32768.
  - i1 <= sat19(i1 + scaled_q − fb).
  - i2 <= sat21(i2 + i1 − fb).
  - `pdm_o` <= (next i2 ≥ 0).
  - satN clamps to the signed N-bit range.
- The modulator never stops. In MUTED its input is 0, giving a 50 % density idle tone.
- `audio_valid_i` coinciding with a state change: the sample is latched normally. Sample path and gain path are independent.

## Timing
- Reset values: `pdm_o`=0, `active_o`=0, state MUTED, gain 0, `smp_q`=0, `scaled_q`=0, prescaler 0, acc/i1/i2 = 0.
- Reset mid-ramp returns immediately to MUTED with gain 0.
- Latency:
  - `audio_valid_i` at cycle N → `smp_q` at N+1 → `scaled_q` at N+2 → first affected `pdm_o` bit at N+3.
  - `enable_i` rise at N → state RAMP_UP and `active_o`=1 at N+1.
  - First gain increment at N+1+2^RAMP_STEP_LOG2.
- `active_o` falls in the cycle after gain reaches 0.

## Configuration
- Macro `PDM_DAC_ORDER2_EN`.
  - Defined: second-order modulator (i1/i2 integrators with saturation).
  - Undefined: first-order carry modulator only; i1/i2 are not instantiated.
- Ports, latency and state machine are identical in both builds.

## Structure
- Shared package `tt6581_pkg` holds:
  - `audio_t` (logic signed [15:0]);
  - `pdm_state_e` (MUTED, RAMP_UP, RUN, RAMP_DOWN);
  - `GAIN_UNITY` = 9'd256.
- One sub-module, `pdm_mod`, contains the modulator core. Input is `scaled_q`; output is `pdm_o`; it holds the order-select `ifdef`.
- The ramp FSM, sample register and gain multiply stay in `pdm_dac`.
- The top level connects `audio_o`/`audio_valid_o` from the controller and routes `pdm_o` to an output pin.

## Test plan
- Reset, `enable_i`=0, first-order → `pdm_o` = 0,1,0,1… from the first cycle after reset release; `active_o`=0.
- RAMP_STEP_LOG2=2, `enable_i`↑ → RUN after 256·4 clocks, plus or minus 1; gain monotonic. Drop `enable_i` at gain 100 → ramps down from 100 to 0, then MUTED, `active_o`=0.
- Sample 16'h7FFF at unity gain → exactly 65535 ones per 65536 cycles (first-order). 16'h8000 → all zeros after settling.
- Sample 16'h4000 at unity gain → 75 % ones ±1 per 1024-cycle window, in both `PDM_DAC_ORDER2_EN` builds.
- `audio_valid_i` at cycle N with a new value → `scaled_q` changes at N+2, and the `pdm_o` density changes from N+3.
- Assert `rst_ni` during RAMP_UP at gain 50 → all outputs at reset values asynchronously. After release, MUTED with gain 0.

Source files
------------

// File: rtl/tt6581_pkg.sv
// Shared audio types, ramp states and gain constants for the tt6581 audio path.
package tt6581_pkg;

  localparam int unsigned AUDIO_W = 16;
  localparam int unsigned GAIN_W  = 9;

  typedef logic signed [AUDIO_W-1:0] audio_t;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } pdm_state_e;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

endpackage

// File: rtl/pdm_mod.sv
// Delta-sigma modulator core: signed sample in, one PDM bit per clock out.
// Build option: define PDM_DAC_ORDER2_EN for the second-order saturating
// modulator; otherwise a first-order carry modulator is built.
module pdm_mod
  import tt6581_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  audio_t scaled,
  output logic   pdm
);

`ifdef PDM_DAC_ORDER2_EN
  localparam int unsigned I1_W = 19;
  localparam int unsigned I2_W = 21;
  localparam int unsigned S1_W = I1_W + 2;
  localparam int unsigned S2_W = I2_W + 2;

  localparam logic signed [S1_W-1:0] I1_MAX = 21'sd262143;
  localparam logic signed [S1_W-1:0] I1_MIN = -21'sd262144;
  localparam logic signed [S2_W-1:0] I2_MAX = 23'sd1048575;
  localparam logic signed [S2_W-1:0] I2_MIN = -23'sd1048576;

  logic signed [I1_W-1:0] i1_q, i1_d;
  logic signed [I2_W-1:0] i2_q, i2_d;
  logic signed [17:0]     fb_c;
  logic signed [S1_W-1:0] s1_c;
  logic signed [S2_W-1:0] s2_c;

  // Two cascaded integrators with clamping; the second stage integrates the
  // freshly updated first stage so the loop has a classic (1-z^-1)^2 shaping.
  always_comb begin
    fb_c = pdm ? 18'sd32767 : -18'sd32768;
    s1_c = S1_W'(i1_q) + S1_W'(scaled) - S1_W'(fb_c);
    if (s1_c > I1_MAX)      i1_d = I1_W'(I1_MAX);
    else if (s1_c < I1_MIN) i1_d = I1_W'(I1_MIN);
    else                    i1_d = I1_W'(s1_c);
    s2_c = S2_W'(i2_q) + S2_W'(i1_d) - S2_W'(fb_c);
    if (s2_c > I2_MAX)      i2_d = I2_W'(I2_MAX);
    else if (s2_c < I2_MIN) i2_d = I2_W'(I2_MIN);
    else                    i2_d = I2_W'(s2_c);
  end

  // Integrator state and quantiser output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q <= '0;
      i2_q <= '0;
      pdm  <= 1'b0;
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
      pdm  <= ~i2_d[I2_W-1];
    end
  end
`else
  logic [AUDIO_W-1:0] acc_q;
  logic [AUDIO_W:0]   sum_c;

  // Offset-binary input into a wrapping accumulator; the carry is the bit.
  assign sum_c = {1'b0, acc_q} + {1'b0, ~scaled[AUDIO_W-1], scaled[AUDIO_W-2:0]};

  // Accumulator and carry output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      pdm   <= 1'b0;
    end else begin
      acc_q <= sum_c[AUDIO_W-1:0];
      pdm   <= sum_c[AUDIO_W];
    end
  end
`endif

endmodule

// File: rtl/pdm_dac.sv
// PDM audio DAC: sample hold, click-free mute/unmute gain ramp, modulator.
// Build option: PDM_DAC_ORDER2_EN selects the second-order modulator in pdm_mod.
module pdm_dac
  import tt6581_pkg::*;
#(
  parameter int unsigned RAMP_STEP_LOG2 = 8
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   audio_valid_i,
  input  audio_t audio_i,
  input  logic   enable_i,
  output logic   pdm_o,
  output logic   active_o
);

  localparam int unsigned PRE_W  = RAMP_STEP_LOG2;
  localparam int unsigned PROD_W = AUDIO_W + GAIN_W + 1;

  pdm_state_e        state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  audio_t            smp_q;
  audio_t            scaled_q;
  logic              active_q;
  logic              tick_c;
  logic signed [PROD_W-1:0] prod_c;

  assign tick_c = &pre_q;

  // Ramp FSM next state, gain update and step prescaler.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    case (state_q)
      MUTED: begin
        gain_d = '0;
        if (enable_i) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable_i)                 state_d = RAMP_DOWN;
        else if (gain_q == GAIN_UNITY) state_d = RUN;
        else if (tick_c)               gain_d  = gain_q + GAIN_W'(1);
      end
      RUN: begin
        gain_d = GAIN_UNITY;
        if (!enable_i) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (enable_i)           state_d = RAMP_UP;
        else if (gain_q == '0)  state_d = MUTED;
        else if (tick_c)        gain_d  = gain_q - GAIN_W'(1);
      end
      default: begin
        state_d = MUTED;
        gain_d  = '0;
      end
    endcase
    pre_d = (state_d != state_q) ? '0 : pre_q + PRE_W'(1);
  end

  // FSM, gain and prescaler registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MUTED;
      gain_q   <= '0;
      pre_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      pre_q    <= pre_d;
      active_q <= (state_d != MUTED);
    end
  end

  // Gain is at most unity, so bits [23:8] of the product always fit 16 bits.
  assign prod_c = PROD_W'(smp_q) * PROD_W'($signed({1'b0, gain_q}));

  // Zero-order sample hold and registered gain multiply.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      smp_q    <= '0;
      scaled_q <= '0;
    end else begin
      if (audio_valid_i) smp_q <= audio_i;
      scaled_q <= prod_c[AUDIO_W+7:8];
    end
  end

  pdm_mod u_mod (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .scaled (scaled_q),
    .pdm    (pdm_o)
  );

  assign active_o = active_q;

endmodule

// File: tb/tb_pdm_dac.sv
// Self-checking bench for pdm_dac with a fast ramp (RAMP_STEP_LOG2 = 2).
module tb_pdm_dac;

  localparam int unsigned STEP = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               audio_valid;
  logic signed [15:0] audio;
  logic               enable;
  logic               pdm;
  logic               active;

  int total = 0;
  int bad   = 0;

  pdm_dac #(.RAMP_STEP_LOG2(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .audio_valid_i (audio_valid),
    .audio_i       (audio),
    .enable_i      (enable),
    .pdm_o         (pdm),
    .active_o      (active)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one strobe; returns at the negedge after the loading edge.
  task automatic send_sample(input logic signed [15:0] s);
    audio       = s;
    audio_valid = 1'b1;
    @(negedge clk);
    audio_valid = 1'b0;
  endtask

  task automatic wait_muted();
    int n = 0;
    enable = 1'b0;
    while (active !== 1'b0 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (active !== 1'b0) begin
      bad++;
      $display("FAIL wait_muted: active=%b required 0 within 1500 cycles", active);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; audio_valid = 1'b0; audio = '0; enable = 1'b0;
    cyc(3);
    total++;
    if (pdm !== 1'b0 || active !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: pdm=%b active=%b required 0 0", pdm, active);
    end
    rst_n = 1'b1;
`ifndef PDM_DAC_ORDER2_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++;
      if (pdm !== 1'(i % 2) || active !== 1'b0) begin
        bad++;
        $display("FAIL idle_tone[%0d]: pdm=%b active=%b required %0d 0", i, pdm, active, i % 2);
      end
    end
`else
    cyc(16);
`endif
  endtask

  // Up-ramp to unity from MUTED with a random held sample, then a down-ramp
  // started at gain 100. Expected gain is derived from elapsed clocks.
  task automatic test_ramp();
    logic signed [15:0] s;
    int g_exp, g_prev, sc_exp;
    s = 16'($urandom);
    send_sample(s);
    cyc(3);
    enable = 1'b1;
    g_prev = 0;
    for (int m = 0; m <= 1030; m++) begin
      @(negedge clk);
      g_exp  = (m / STEP > 256) ? 256 : m / STEP;
      sc_exp = (int'(s) * g_prev) >>> 8;
      total++;
      if (dut.gain_q !== 9'(g_exp) || active !== 1'b1) begin
        bad++;
        $display("FAIL ramp_up[%0d]: gain=%0d active=%b required %0d 1", m, dut.gain_q, active, g_exp);
      end
      total++;
      if (dut.scaled_q !== 16'(sc_exp)) begin
        bad++;
        $display("FAIL ramp_scaled[%0d]: scaled=%0d required %0d", m, $signed(dut.scaled_q), sc_exp);
      end
      g_prev = g_exp;
    end
    wait_muted();
    enable = 1'b1;
    cyc(401);
    total++;
    if (dut.gain_q !== 9'd100) begin
      bad++;
      $display("FAIL ramp_to_100: gain=%0d required 100", dut.gain_q);
    end
    enable = 1'b0;
    for (int k = 0; k <= 402; k++) begin
      @(negedge clk);
      g_exp = (100 - k / STEP < 0) ? 0 : 100 - k / STEP;
      total++;
      if (dut.gain_q !== 9'(g_exp) || active !== 1'(k <= 400)) begin
        bad++;
        $display("FAIL ramp_down[%0d]: gain=%0d active=%b required %0d %0d", k, dut.gain_q, active, g_exp, k <= 400);
      end
    end
  endtask

  task automatic reach_unity();
    int n = 0;
    enable = 1'b1;
    while (dut.gain_q !== 9'd256 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    cyc(2);
    total++;
    if (dut.gain_q !== 9'd256 || active !== 1'b1) begin
      bad++;
      $display("FAIL reach_unity: gain=%0d active=%b required 256 1", dut.gain_q, active);
    end
  endtask

  task automatic test_full_scale();
    int ones;
    reach_unity();
`ifndef PDM_DAC_ORDER2_EN
    send_sample(16'sh7FFF);
    cyc(4);
    ones = 0;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      ones += int'(pdm);
    end
    total++;
    if (ones !== 65535) begin
      bad++;
      $display("FAIL full_pos: ones=%0d required 65535", ones);
    end
    send_sample(16'sh8000);
    @(negedge clk);
    total++;
    if (dut.scaled_q !== 16'h8000) begin
      bad++;
      $display("FAIL neg_latency: scaled=%h required 8000", dut.scaled_q);
    end
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ones += int'(pdm);
    end
    total++;
    if (ones !== 0) begin
      bad++;
      $display("FAIL full_neg: ones=%0d required 0", ones);
    end
`endif
    send_sample(16'sh4000);
    cyc(8);
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      ones += int'(pdm);
    end
    total++;
    if (ones < 767 || ones > 769) begin
      bad++;
      $display("FAIL quarter_window: ones=%0d required 768+-1", ones);
    end
  endtask

  // Random samples at unity: two-cycle scaled latency and window density.
  task automatic test_random();
    logic signed [15:0] s, prev;
    int ones, xu, diff, tol;
`ifdef PDM_DAC_ORDER2_EN
    tol = 192;
`else
    tol = 64;
`endif
    prev = dut.scaled_q;
    for (int t = 0; t < 6; t++) begin
      s = 16'($urandom);
      if (s == prev) s = s ^ 16'sh0101;
      send_sample(s);
      total++;
      if (dut.scaled_q !== prev) begin
        bad++;
        $display("FAIL rnd_hold[%0d]: scaled=%h required %h", t, dut.scaled_q, prev);
      end
      @(negedge clk);
      total++;
      if (dut.scaled_q !== s) begin
        bad++;
        $display("FAIL rnd_scaled[%0d]: scaled=%h required %h", t, dut.scaled_q, s);
      end
      cyc(8);
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
        @(negedge clk);
        ones += int'(pdm);
      end
      xu   = int'(s) + 32768;
      diff = ones * 64 - xu;
      total++;
      if (diff < -tol || diff > tol) begin
        bad++;
        $display("FAIL rnd_density[%0d]: ones=%0d required about %0d", t, ones, xu / 64);
      end
      prev = s;
    end
  endtask

  task automatic test_reset_mid_ramp();
    wait_muted();
    enable = 1'b1;
    cyc(201);
    total++;
    if (dut.gain_q !== 9'd50) begin
      bad++;
      $display("FAIL mid_ramp_gain: gain=%0d required 50", dut.gain_q);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (pdm !== 1'b0 || active !== 1'b0 || dut.gain_q !== 9'd0 || dut.scaled_q !== 16'd0) begin
      bad++;
      $display("FAIL async_reset: pdm=%b active=%b gain=%0d scaled=%0d required 0 0 0 0",
               pdm, active, dut.gain_q, $signed(dut.scaled_q));
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5);
    total++;
    if (active !== 1'b0 || dut.gain_q !== 9'd0) begin
      bad++;
      $display("FAIL post_reset: active=%b gain=%0d required 0 0", active, dut.gain_q);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_full_scale();
    test_random();
    test_reset_mid_ramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
